teclado_entrada_nbits: RTL and testbench

Keypad entry block, the input-side counterpart of the seven-segment display path. It scans a 4x4 matrix keypad, debounces presses, and accumulates decimal digits into an unsigned CANT_BITS-bit binary value. On the enter key it publishes that value on regNbits with a one-cycle valid pulse. The in-progress value is exported so the display path can echo it while the user types.

---
 rtl/teclado_entrada_nbits_pkg.sv | 42 ++++
 rtl/teclado_entrada_nbits_tick_ms.sv | 26 ++
 rtl/teclado_entrada_nbits.sv | 149 ++++++++++++++
 tb/tb_teclado_entrada_nbits.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_entrada_nbits_pkg.sv
// Shared key codes, FSM states and the keypad row/column lookup for the keypad entry path.
package teclado_entrada_nbits_pkg;

    typedef enum logic [3:0] {
        TECLA_0   = 4'd0,
        TECLA_1   = 4'd1,
        TECLA_2   = 4'd2,
        TECLA_3   = 4'd3,
        TECLA_4   = 4'd4,
        TECLA_5   = 4'd5,
        TECLA_6   = 4'd6,
        TECLA_7   = 4'd7,
        TECLA_8   = 4'd8,
        TECLA_9   = 4'd9,
        TECLA_A   = 4'd10,
        TECLA_B   = 4'd11,
        TECLA_C   = 4'd12,
        TECLA_D   = 4'd13,
        TECLA_AST = 4'd14,
        TECLA_NUM = 4'd15
    } tecla_t;

    typedef enum logic [1:0] {
        ESCANEO = 2'd0,
        FILTRO  = 2'd1,
        ACCION  = 2'd2,
        SOLTAR  = 2'd3
    } estado_t;

    // Indexed by {fila, columna}; the first entry listed is row 3 / column 3.
    localparam logic [15:0][3:0] MAPA_TECLAS = {
        TECLA_D, TECLA_NUM, TECLA_0, TECLA_AST,
        TECLA_C, TECLA_9,   TECLA_8, TECLA_7,
        TECLA_B, TECLA_6,   TECLA_5, TECLA_4,
        TECLA_A, TECLA_3,   TECLA_2, TECLA_1
    };

    function automatic logic [3:0] tecla_de(input logic [1:0] fila, input logic [1:0] col);
        return MAPA_TECLAS[{fila, col}];
    endfunction

endpackage

// File: rtl/teclado_entrada_nbits_tick_ms.sv
// Millisecond prescaler: one-cycle tick every CICLOS_MS clocks, first one CICLOS_MS cycles after reset.
module tick_ms #(
    parameter int CICLOS_MS = 50000
) (
    input  logic reloj_FPGA,
    input  logic reset,
    output logic tick
);
    localparam int CW = (CICLOS_MS > 1) ? $clog2(CICLOS_MS) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_MS - 1);

    logic [CW-1:0] cuenta_reg;

    always_ff @(posedge reloj_FPGA or posedge reset) begin
        if (reset) begin
            cuenta_reg <= '0;
        end else if (cuenta_reg == ULTIMO) begin
            cuenta_reg <= '0;
        end else begin
            cuenta_reg <= cuenta_reg + 1'b1;
        end
    end

    assign tick = (cuenta_reg == ULTIMO);

endmodule

// File: rtl/teclado_entrada_nbits.sv
// 4x4 keypad scanner/debouncer accumulating decimal digits into a CANT_BITS binary value.
// Define TECLADO_BORRAR_EN to make key B a backspace (acumulado / 10).
module teclado_entrada_nbits
    import teclado_entrada_nbits_pkg::*;
#(
    parameter int CANT_BITS   = 12,
    parameter int CICLOS_MS   = 50000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                 reloj_FPGA,
    input  logic                 reset,
    input  logic [3:0]           filas,
    output logic [3:0]           columnas,
    output logic [CANT_BITS-1:0] acumulado,
    output logic [CANT_BITS-1:0] regNbits,
    output logic                 dato_valido,
    output logic                 desborde
);
    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_MS);
    localparam logic [CANT_BITS+3:0] DIEZ = (CANT_BITS+4)'(10);

    logic                 tick;
    logic [3:0]           filas_meta_reg, filas_sync_reg;
    estado_t              estado_reg;
    logic [1:0]           col_reg;
    logic [3:0]           tecla_reg;
    logic [3:0]           patron_reg;
    logic [CW-1:0]        cuenta_reg;
    logic [CW-1:0]        cuenta_inc;
    logic [CANT_BITS-1:0] acumulado_reg, regNbits_reg;
    logic                 dato_valido_reg, desborde_reg;

    logic [3:0]           bajas;
    logic                 una_fila;
    logic [1:0]           fila_idx;
    logic [CANT_BITS+3:0] siguiente;

    tick_ms #(.CICLOS_MS(CICLOS_MS)) u_tick (
        .reloj_FPGA (reloj_FPGA),
        .reset      (reset),
        .tick       (tick)
    );

    assign bajas      = ~filas_sync_reg;
    assign una_fila   = (bajas != 4'd0) && ((bajas & (bajas - 4'd1)) == 4'd0);
    assign cuenta_inc = cuenta_reg + 1'b1;
    // Wide enough that (2^CANT_BITS-1)*10+9 never wraps, so the top nibble flags overflow.
    assign siguiente  = ({4'b0000, acumulado_reg} * DIEZ) + {{CANT_BITS{1'b0}}, tecla_reg};

    always_comb begin
        fila_idx = 2'd0;
        case (bajas)
            4'b0010: fila_idx = 2'd1;
            4'b0100: fila_idx = 2'd2;
            4'b1000: fila_idx = 2'd3;
            default: fila_idx = 2'd0;
        endcase
    end

`ifdef TECLADO_BORRAR_EN
    logic [CANT_BITS-1:0] acumulado_div10;
    assign acumulado_div10 = acumulado_reg / CANT_BITS'(10);
`endif

    always_ff @(posedge reloj_FPGA or posedge reset) begin
        if (reset) begin
            filas_meta_reg  <= 4'hF;
            filas_sync_reg  <= 4'hF;
            estado_reg      <= ESCANEO;
            col_reg         <= 2'd0;
            tecla_reg       <= 4'd0;
            patron_reg      <= 4'hF;
            cuenta_reg      <= '0;
            acumulado_reg   <= '0;
            regNbits_reg    <= '0;
            dato_valido_reg <= 1'b0;
            desborde_reg    <= 1'b0;
        end else begin
            filas_meta_reg  <= filas;
            filas_sync_reg  <= filas_meta_reg;
            dato_valido_reg <= 1'b0;
            case (estado_reg)
                ESCANEO: if (tick) begin
                    if (una_fila) begin
                        tecla_reg  <= tecla_de(fila_idx, col_reg);
                        patron_reg <= filas_sync_reg;
                        cuenta_reg <= '0;
                        estado_reg <= FILTRO;
                    end else begin
                        col_reg <= col_reg + 2'd1;
                    end
                end
                FILTRO: if (tick) begin
                    if (filas_sync_reg == patron_reg) begin
                        cuenta_reg <= cuenta_inc;
                        if (cuenta_inc == DEB) estado_reg <= ACCION;
                    end else begin
                        estado_reg <= ESCANEO;
                        col_reg    <= col_reg + 2'd1;
                    end
                end
                ACCION: begin
                    cuenta_reg <= '0;
                    estado_reg <= SOLTAR;
                    if (tecla_reg <= TECLA_9) begin
                        if (siguiente[CANT_BITS+3:CANT_BITS] == 4'd0)
                            acumulado_reg <= siguiente[CANT_BITS-1:0];
                        else
                            desborde_reg <= 1'b1;
                    end else if (tecla_reg == TECLA_A) begin
                        regNbits_reg    <= acumulado_reg;
                        dato_valido_reg <= 1'b1;
                        acumulado_reg   <= '0;
                        desborde_reg    <= 1'b0;
                    end else if (tecla_reg == TECLA_C) begin
                        acumulado_reg <= '0;
                        desborde_reg  <= 1'b0;
`ifdef TECLADO_BORRAR_EN
                    end else if (tecla_reg == TECLA_B) begin
                        acumulado_reg <= acumulado_div10;
                        desborde_reg  <= 1'b0;
`endif
                    end
                end
                SOLTAR: if (tick) begin
                    // Any low row restarts the release count, so a held key never repeats.
                    if (filas_sync_reg == 4'hF) begin
                        cuenta_reg <= cuenta_inc;
                        if (cuenta_inc == DEB) begin
                            estado_reg <= ESCANEO;
                            col_reg    <= col_reg + 2'd1;
                        end
                    end else begin
                        cuenta_reg <= '0;
                    end
                end
                default: estado_reg <= ESCANEO;
            endcase
        end
    end

    assign columnas    = ~(4'b0001 << col_reg);
    assign acumulado   = acumulado_reg;
    assign regNbits    = regNbits_reg;
    assign dato_valido = dato_valido_reg;
    assign desborde    = desborde_reg;

endmodule

// File: tb/tb_teclado_entrada_nbits.sv
// Self-checking bench for teclado_entrada_nbits with a switch-matrix keypad model.
module tb_teclado_entrada_nbits;
    localparam int CANT_BITS   = 12;
    localparam int CICLOS_MS   = 4;
    localparam int DEBOUNCE_MS = 3;
    localparam int MAX_VAL     = (1 << CANT_BITS) - 1;

    logic                 reloj_FPGA = 1'b0;
    logic                 reset;
    logic [3:0]           filas;
    logic [3:0]           columnas;
    logic [CANT_BITS-1:0] acumulado;
    logic [CANT_BITS-1:0] regNbits;
    logic                 dato_valido;
    logic                 desborde;

    logic [15:0] pulsadas;
    int n_vec = 0;
    int n_err = 0;
    int pulsos = 0;
    int exp_acc = 0;
    int exp_reg = 0;
    int exp_pulsos = 0;
    bit exp_desb = 1'b0;

    teclado_entrada_nbits #(
        .CANT_BITS   (CANT_BITS),
        .CICLOS_MS   (CICLOS_MS),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) dut (
        .reloj_FPGA  (reloj_FPGA),
        .reset       (reset),
        .filas       (filas),
        .columnas    (columnas),
        .acumulado   (acumulado),
        .regNbits    (regNbits),
        .dato_valido (dato_valido),
        .desborde    (desborde)
    );

    always #5 reloj_FPGA = ~reloj_FPGA;

    // A pressed switch pulls its row low only while its column is driven low.
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pulsadas[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    always @(posedge reloj_FPGA) if (dato_valido === 1'b1) pulsos++;

    // Key code (0-9, A=10, B=11, C=12, D=13, *=14, #=15) to switch index row*4+col.
    function automatic int tecla_idx(input int k);
        if (k >= 1 && k <= 9) return ((k - 1) / 3) * 4 + (k - 1) % 3;
        case (k)
            0:  return 13;
            10: return 3;
            11: return 7;
            12: return 11;
            13: return 15;
            14: return 12;
            default: return 14;
        endcase
    endfunction

    task automatic modelo(input int k);
        if (k < 10) begin
            if (exp_acc * 10 + k <= MAX_VAL) exp_acc = exp_acc * 10 + k;
            else exp_desb = 1'b1;
        end else if (k == 10) begin
            exp_reg = exp_acc; exp_pulsos++; exp_acc = 0; exp_desb = 1'b0;
        end else if (k == 12) begin
            exp_acc = 0; exp_desb = 1'b0;
`ifdef TECLADO_BORRAR_EN
        end else if (k == 11) begin
            exp_acc = exp_acc / 10; exp_desb = 1'b0;
`endif
        end
    endtask

    task automatic esperar_ticks(input int n);
        repeat (n * CICLOS_MS) @(negedge reloj_FPGA);
    endtask

    task automatic pulsar(input int k);
        pulsadas[tecla_idx(k)] = 1'b1;
        esperar_ticks(12);
        pulsadas = '0;
        esperar_ticks(8);
        modelo(k);
    endtask

    task automatic test_reset;
        logic [3:0] esp_col;
        logic [3:0] previo;
        int n;
        reset = 1'b1;
        pulsadas = '0;
        repeat (3) @(negedge reloj_FPGA);
        n_vec++; if (columnas !== 4'b1110) begin n_err++; $display("FAIL reset_columnas: got %b expected 1110", columnas); end
        n_vec++; if (acumulado !== '0 || regNbits !== '0 || dato_valido !== 1'b0 || desborde !== 1'b0) begin
            n_err++; $display("FAIL reset_salidas: got acc=%0d reg=%0d dv=%b desb=%b expected all 0", acumulado, regNbits, dato_valido, desborde);
        end
        reset = 1'b0;
        esp_col = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            esp_col = {esp_col[2:0], esp_col[3]};
            previo = columnas;
            n = 0;
            while (columnas === previo && n < 3 * CICLOS_MS) begin
                @(negedge reloj_FPGA);
                n++;
            end
            n_vec++; if (columnas !== esp_col) begin n_err++; $display("FAIL scan_columna%0d: got %b expected %b", i, columnas, esp_col); end
            if (i == 0) begin
                n_vec++; if (n != CICLOS_MS) begin n_err++; $display("FAIL primer_tick: got %0d cycles expected %0d", n, CICLOS_MS); end
            end
            n_vec++; if (acumulado !== '0 || pulsos != 0 || desborde !== 1'b0) begin
                n_err++; $display("FAIL scan_reposo%0d: got acc=%0d pulsos=%0d desb=%b expected 0", i, acumulado, pulsos, desborde);
            end
        end
    endtask

    task automatic test_digitos;
        int seq[4] = '{4, 0, 9, 10};
        for (int i = 0; i < 4; i++) begin
            pulsar(seq[i]);
            n_vec++; if (int'(acumulado) != exp_acc) begin n_err++; $display("FAIL digitos_acc%0d: got %0d expected %0d", i, acumulado, exp_acc); end
        end
        n_vec++; if (int'(regNbits) != exp_reg || exp_reg != 409) begin n_err++; $display("FAIL digitos_reg: got %0d expected 409", regNbits); end
        n_vec++; if (pulsos != exp_pulsos) begin n_err++; $display("FAIL digitos_pulsos: got %0d expected %0d", pulsos, exp_pulsos); end
    endtask

    task automatic test_desborde;
        int seq[6] = '{4, 0, 9, 5, 5, 12};
        for (int i = 0; i < 6; i++) begin
            pulsar(seq[i]);
            n_vec++; if (int'(acumulado) != exp_acc || desborde !== exp_desb) begin
                n_err++; $display("FAIL desborde_paso%0d: got acc=%0d desb=%b expected acc=%0d desb=%b", i, acumulado, desborde, exp_acc, exp_desb);
            end
        end
    endtask

    task automatic test_rebote;
        int antes;
        antes = exp_acc;
        for (int i = 0; i < 5; i++) begin
            pulsadas[tecla_idx(7)] = 1'b1;
            esperar_ticks(2);
            if (i < 4) begin
                pulsadas = '0;
                esperar_ticks(2);
            end
        end
        n_vec++; if (int'(acumulado) != antes || pulsos != exp_pulsos) begin
            n_err++; $display("FAIL rebote_sin_accion: got acc=%0d expected %0d", acumulado, antes);
        end
        esperar_ticks(12);
        pulsadas = '0;
        esperar_ticks(8);
        modelo(7);
        n_vec++; if (int'(acumulado) != exp_acc) begin n_err++; $display("FAIL rebote_un_digito: got %0d expected %0d", acumulado, exp_acc); end
    endtask

    task automatic test_mantener;
        pulsadas[tecla_idx(3)] = 1'b1;
        esperar_ticks(100);
        modelo(3);
        n_vec++; if (int'(acumulado) != exp_acc) begin n_err++; $display("FAIL mantener_mitad: got %0d expected %0d", acumulado, exp_acc); end
        esperar_ticks(100);
        pulsadas = '0;
        esperar_ticks(8);
        n_vec++; if (int'(acumulado) != exp_acc) begin n_err++; $display("FAIL mantener_fin: got %0d expected %0d", acumulado, exp_acc); end
    endtask

    task automatic test_dos_filas;
        pulsadas[tecla_idx(1)] = 1'b1;
        pulsadas[tecla_idx(4)] = 1'b1;
        esperar_ticks(20);
        pulsadas = '0;
        esperar_ticks(8);
        n_vec++; if (int'(acumulado) != exp_acc || pulsos != exp_pulsos) begin
            n_err++; $display("FAIL dos_filas: got acc=%0d pulsos=%0d expected acc=%0d pulsos=%0d", acumulado, pulsos, exp_acc, exp_pulsos);
        end
    endtask

    task automatic test_reset_filtro;
        int n;
        pulsadas[tecla_idx(5)] = 1'b1;
        n = 0;
        while (columnas !== 4'b1101 && n < 6 * CICLOS_MS) begin
            @(negedge reloj_FPGA);
            n++;
        end
        n_vec++; if (columnas !== 4'b1101) begin n_err++; $display("FAIL filtro_columna: got %b expected 1101", columnas); end
        repeat (8) @(negedge reloj_FPGA);
        reset = 1'b1;
        repeat (2) @(negedge reloj_FPGA);
        pulsadas = '0;
        exp_acc = 0; exp_reg = 0; exp_desb = 1'b0;
        n_vec++; if (columnas !== 4'b1110 || acumulado !== '0 || regNbits !== '0 || dato_valido !== 1'b0 || desborde !== 1'b0) begin
            n_err++; $display("FAIL filtro_reset: got col=%b acc=%0d reg=%0d dv=%b desb=%b", columnas, acumulado, regNbits, dato_valido, desborde);
        end
        reset = 1'b0;
        esperar_ticks(10);
        n_vec++; if (int'(acumulado) != 0 || pulsos != exp_pulsos) begin
            n_err++; $display("FAIL filtro_sin_digito: got acc=%0d pulsos=%0d expected 0 / %0d", acumulado, pulsos, exp_pulsos);
        end
    endtask

    task automatic test_aleatorio;
        int v;
        int digs[$];
        for (int it = 0; it < 6; it++) begin
            v = (it == 0) ? 0 : int'($urandom_range(0, 9999));
            digs.delete();
            if (v == 0) digs.push_back(0);
            while (v > 0) begin digs.push_front(v % 10); v = v / 10; end
            foreach (digs[j]) begin
                pulsar(digs[j]);
                n_vec++; if (int'(acumulado) != exp_acc || desborde !== exp_desb) begin
                    n_err++; $display("FAIL aleatorio%0d_dig%0d: got acc=%0d desb=%b expected acc=%0d desb=%b", it, j, acumulado, desborde, exp_acc, exp_desb);
                end
            end
            pulsar(int'($urandom_range(13, 15)));
            pulsar(10);
            n_vec++; if (int'(regNbits) != exp_reg || int'(acumulado) != 0 || desborde !== 1'b0 || pulsos != exp_pulsos) begin
                n_err++; $display("FAIL aleatorio%0d_enter: got reg=%0d acc=%0d pulsos=%0d expected reg=%0d pulsos=%0d", it, regNbits, acumulado, pulsos, exp_reg, exp_pulsos);
            end
        end
    endtask

    task automatic test_borrar;
        int seq[4] = '{1, 2, 3, 11};
        foreach (seq[i]) pulsar(seq[i]);
        n_vec++; if (int'(acumulado) != exp_acc || desborde !== exp_desb) begin
            n_err++; $display("FAIL tecla_b: got acc=%0d desb=%b expected acc=%0d desb=%b", acumulado, desborde, exp_acc, exp_desb);
        end
    endtask

    initial begin
        reset = 1'b1;
        pulsadas = '0;
        test_reset;
        test_digitos;
        test_desborde;
        test_rebote;
        test_mantener;
        test_dos_filas;
        test_reset_filtro;
        test_aleatorio;
        test_borrar;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
